// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key event classifier.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } key_state_e;

  localparam int DEF_LONG_TICKS   = 50_000_000;
  localparam int DEF_GAP_TICKS    = 12_500_000;
  localparam int DEF_REPEAT_TICKS = 5_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // $clog2(N) bits are enough to reach N-1, the largest compare value.
  localparam int DEF_CNT_W =
    $clog2(max3(DEF_LONG_TICKS, DEF_GAP_TICKS, DEF_REPEAT_TICKS));

endpackage

// File: rtl/key_evt_timer.sv
// Free-running state timer: synchronous clear, +1 per clock, terminal-count flag.
module key_evt_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = clr ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign tc = (count_q == limit);

endmodule

// File: rtl/key_event_classifier.sv
// Classifies debounced key press/release pulses into short, long and double clicks.
// Optional auto-repeat while held long is enabled by defining KEY_REPEAT_EN.
module key_event_classifier
  import key_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int GAP_TICKS    = DEF_GAP_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic press_down,
  input  logic press_up,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic key_held
`ifdef KEY_REPEAT_EN
  ,
  output logic repeat_pulse
`endif
);

  key_state_e       state_q, state_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic             held_q, held_d;
  logic             timer_clr;
  logic             timer_tc;
  logic [CNT_W-1:0] timer_limit;
`ifdef KEY_REPEAT_EN
  logic             rep_q, rep_d;
`endif

  // The compare value follows the state the timer is currently measuring.
  always_comb begin
    case (state_q)
      PRESS1:  timer_limit = CNT_W'(LONG_TICKS - 1);
      GAP:     timer_limit = CNT_W'(GAP_TICKS - 1);
      default: timer_limit = CNT_W'(REPEAT_TICKS - 1);
    endcase
  end

  key_evt_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .limit (timer_limit),
    .tc    (timer_tc)
  );

  // Input events are checked before timeouts so an event on the terminal cycle wins.
  always_comb begin
    state_d   = state_q;
    short_d   = 1'b0;
    long_d    = 1'b0;
    dbl_d     = 1'b0;
    timer_clr = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (press_down) state_d = PRESS1;
      end
      PRESS1: begin
        if (press_up) begin
          state_d = GAP;
        end else if (timer_tc) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      GAP: begin
        if (press_down) begin
          state_d = PRESS2;
        end else if (timer_tc) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (press_up) begin
          state_d = IDLE;
          dbl_d   = 1'b1;
        end
      end
      LONG: begin
        if (press_up) begin
          state_d = IDLE;
        end
`ifdef KEY_REPEAT_EN
        else if (timer_tc) begin
          rep_d     = 1'b1;
          timer_clr = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_clr = 1'b1;
    held_d = (state_d == PRESS1) || (state_d == PRESS2) || (state_d == LONG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      held_q  <= held_d;
`ifdef KEY_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign key_held     = held_q;
`ifdef KEY_REPEAT_EN
  assign repeat_pulse = rep_q;
`endif

endmodule

// File: tb/tb_key_event_classifier.sv
// Directed bench for key_event_classifier with small tick counts (20/8/5, 5-bit timer).
// Cycle c is the interval after the c-th clock edge of a run; inputs "at c" are sampled at its end.
module tb_key_event_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic press_down = 1'b0;
  logic press_up = 1'b0;
  logic short_press, long_press, double_click, key_held;
`ifdef KEY_REPEAT_EN
  logic repeat_pulse;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int n_short, f_short, n_long, f_long, n_dbl, f_dbl;
  int h_first, h_last, h_cnt, n_multi;
  int n_rep, f_rep, l_rep;

  key_event_classifier #(
    .LONG_TICKS   (20),
    .GAP_TICKS    (8),
    .REPEAT_TICKS (5),
    .CNT_W        (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .press_down   (press_down),
    .press_up     (press_up),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .key_held     (key_held)
`ifdef KEY_REPEAT_EN
    ,
    .repeat_pulse (repeat_pulse)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs len cycles, pulsing press_down at d0/d1 and press_up at u0/u1 (-1 = none),
  // and records count and first cycle of every output pulse.
  task automatic run(input int len, input int d0, input int d1, input int u0, input int u1);
    n_short = 0; f_short = -1; n_long = 0; f_long = -1; n_dbl = 0; f_dbl = -1;
    h_first = -1; h_last = -1; h_cnt = 0; n_multi = 0;
    n_rep = 0; f_rep = -1; l_rep = -1;
    for (int c = 0; c < len; c++) begin
      if (short_press === 1'b1) begin n_short++; if (f_short < 0) f_short = c; end
      if (long_press === 1'b1) begin n_long++; if (f_long < 0) f_long = c; end
      if (double_click === 1'b1) begin n_dbl++; if (f_dbl < 0) f_dbl = c; end
      if (key_held === 1'b1) begin h_cnt++; h_last = c; if (h_first < 0) h_first = c; end
      if (int'(short_press) + int'(long_press) + int'(double_click) > 1) n_multi++;
`ifdef KEY_REPEAT_EN
      if (repeat_pulse === 1'b1) begin n_rep++; l_rep = c; if (f_rep < 0) f_rep = c; end
`endif
      press_down = (c == d0) || (c == d1);
      press_up   = (c == u0) || (c == u1);
      @(posedge clk); #1;
    end
    press_down = 1'b0;
    press_up   = 1'b0;
    $display("run d=%0d,%0d u=%0d,%0d: short %0d@%0d long %0d@%0d dbl %0d@%0d held %0d..%0d (%0d) rep %0d",
             d0, d1, u0, u1, n_short, f_short, n_long, f_long, n_dbl, f_dbl, h_first, h_last, h_cnt, n_rep);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_short", short_press, 0);
    chk("rst_long", long_press, 0);
    chk("rst_dbl", double_click, 0);
    chk("rst_held", key_held, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single short click
    run(30, 0, -1, 5, -1);
    chk("s1_short_n", n_short, 1);
    chk("s1_short_at", f_short, 14);
    chk("s1_other", n_long + n_dbl, 0);
    chk("s1_held_first", h_first, 1);
    chk("s1_held_last", h_last, 5);
    chk("s1_held_cnt", h_cnt, 5);

    // Long press, release later
    run(40, 0, -1, 30, -1);
    chk("s2_long_n", n_long, 1);
    chk("s2_long_at", f_long, 21);
    chk("s2_other", n_short + n_dbl, 0);
    chk("s2_held_last", h_last, 30);
    chk("s2_held_cnt", h_cnt, 30);
`ifdef KEY_REPEAT_EN
    chk("s2_rep_n", n_rep, 1);
    chk("s2_rep_at", f_rep, 26);
`endif

    // Double click
    run(30, 0, 8, 4, 12);
    chk("s3_dbl_n", n_dbl, 1);
    chk("s3_dbl_at", f_dbl, 13);
    chk("s3_other", n_short + n_long, 0);
    chk("s3_held_cnt", h_cnt, 8);

    // Second press on the GAP terminal cycle wins over the short timeout
    run(30, 0, 12, 4, 16);
    chk("s4_dbl_n", n_dbl, 1);
    chk("s4_dbl_at", f_dbl, 17);
    chk("s4_short_n", n_short, 0);

    // Release on the PRESS1 terminal cycle wins over long detection
    run(40, 0, -1, 20, -1);
    chk("s5_long_n", n_long, 0);
    chk("s5_short_n", n_short, 1);
    chk("s5_short_at", f_short, 29);

    // Release one cycle later: long only
    run(40, 0, -1, 21, -1);
    chk("s6_long_at", f_long, 21);
    chk("s6_other", n_short + n_dbl, 0);
    chk("s6_held_last", h_last, 21);

`ifdef KEY_REPEAT_EN
    // Auto-repeat while held
    run(50, 0, -1, 42, -1);
    chk("s7_long_at", f_long, 21);
    chk("s7_rep_n", n_rep, 4);
    chk("s7_rep_first", f_rep, 26);
    chk("s7_rep_last", l_rep, 41);
`endif

    // Asynchronous reset in the middle of a press
    run(10, 0, -1, -1, -1);
    chk("r_pre_held", key_held, 1);
    rst = 1'b1;
    #2;
    chk("r_async_held", key_held, 0);
    chk("r_async_pulses", int'(short_press) + int'(long_press) + int'(double_click), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(40, -1, -1, 0, -1);
    chk("r_orphan_pulses", n_short + n_long + n_dbl, 0);
    chk("r_orphan_held", h_cnt, 0);
    run(30, 0, -1, 5, -1);
    chk("r_after_short_at", f_short, 14);
    chk("r_after_other", n_long + n_dbl, 0);

    chk("exclusive_pulses", n_multi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
